mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 8-to-1 single-bit selection mux between eight requesters. Each requester raises a request line and presents one data bit; the arbiter grants one requester at a time, drives the mux select, and registers the selected bit as a serial output stream. A grant is bounded by a programmable hold time, so no requester can starve the others. It sits between the requester logic (switches or upstream FSMs) and the single shared output (LED or serial sink).

---
 rtl/arb_pkg.sv | 33 +++
 rtl/mux_rr_arbiter_mux8to1.sv | 25 ++
 rtl/mux_rr_arbiter.sv | 103 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Holds the FSM state enum, requester sizing and the rotating priority search.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    // First set bit of req, searching upward from ptr+1 and wrapping.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [SEL_W-1:0] ptr
    );
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] win;
        logic             found;
        win   = ptr;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux8to1.sv
// Shared 8-to-1 single-bit selection mux.
// Purely combinational; the arbiter registers its output.
module mux8to1
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] MuxIn,
    input  logic [SEL_W-1:0] MuxSelect,
    output logic             MuxOut
);

    always_comb begin
        case (MuxSelect)
            3'd0:    MuxOut = MuxIn[0];
            3'd1:    MuxOut = MuxIn[1];
            3'd2:    MuxOut = MuxIn[2];
            3'd3:    MuxOut = MuxIn[3];
            3'd4:    MuxOut = MuxIn[4];
            3'd5:    MuxOut = MuxIn[5];
            3'd6:    MuxOut = MuxIn[6];
            3'd7:    MuxOut = MuxIn[7];
            default: MuxOut = MuxIn[0];
        endcase
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 8-to-1 mux between eight requesters.
// Grants are bounded by HOLD_CYCLES and separated by at least one idle cycle.
module mux_rr_arbiter
    import arb_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Enable,
    input  logic [N_REQ-1:0] Req,
    input  logic [N_REQ-1:0] MuxIn,
    output logic [N_REQ-1:0] Grant,
    output logic [SEL_W-1:0] MuxSelect,
    output logic             Out,
    output logic             Valid,
    output logic             Timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    arb_state_t       state;
    arb_state_t       state_d;
    logic [7:0]       cnt;
    logic [7:0]       cnt_d;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W-1:0] sel_d;
    logic [SEL_W-1:0] win;
    logic [N_REQ-1:0] grant_d;
    logic             out_d;
    logic             valid_d;
    logic             tmo_d;
    logic             mux_out;

    mux8to1 u_mux (
        .MuxIn     (MuxIn),
        .MuxSelect (MuxSelect),
        .MuxOut    (mux_out)
    );

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= SEL_W'(N_REQ - 1);
            Grant     <= '0;
            MuxSelect <= '0;
            Out       <= 1'b0;
            Valid     <= 1'b0;
            Timeout   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ptr       <= ptr_d;
            Grant     <= grant_d;
            MuxSelect <= sel_d;
            Out       <= out_d;
            Valid     <= valid_d;
            Timeout   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ptr_d   = ptr;
        grant_d = Grant;
        sel_d   = MuxSelect;
        tmo_d   = 1'b0;
        out_d   = mux_out;
        valid_d = (state == GRANT) && Req[MuxSelect] && Enable;
        win     = rr_pick(Req, ptr);
        unique case (state)
            IDLE: begin
                grant_d = '0;
                if (Enable && (|Req)) begin
                    state_d = GRANT;
                    grant_d = N_REQ'(1) << win;
                    sel_d   = win;
                    ptr_d   = win;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                // A dropped request wins over expiry: plain release, no pulse.
                if (!Enable || !Req[MuxSelect]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter with directed stimulus.
// Valid data is checked by a monitor against a queue of expected beats.
module tb_mux_rr_arbiter;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       Enable;
    logic [7:0] Req;
    logic [7:0] MuxIn;
    logic [7:0] Grant;
    logic [2:0] MuxSelect;
    logic       Out;
    logic       Valid;
    logic       Timeout;

    typedef struct packed {
        logic [2:0] sel;
        logic       out;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    mux_rr_arbiter #(.HOLD_CYCLES(4)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Enable    (Enable),
        .Req       (Req),
        .MuxIn     (MuxIn),
        .Grant     (Grant),
        .MuxSelect (MuxSelect),
        .Out       (Out),
        .Valid     (Valid),
        .Timeout   (Timeout)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int idx, input logic b, input int n);
        exp_t e;
        e.sel = 3'(idx);
        e.out = b;
        repeat (n) sbq.push_back(e);
    endtask

    task automatic step();
        @(negedge Clock);
    endtask

    // Full-length grant: 4 grant cycles, then an idle cycle with Timeout.
    task automatic run_grant(input int idx, input logic b);
        push_exp(idx, b, 4);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("grant", 32'(Grant), 32'(1 << idx));
            chk("sel", 32'(MuxSelect), 32'(idx));
            chk("tmo_low", 32'(Timeout), 0);
        end
        step();
        chk("grant_end", 32'(Grant), 0);
        chk("timeout", 32'(Timeout), 1);
    endtask

    always @(negedge Clock) begin
        if (Valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got Valid=1 Out=%0b expected no beat",
                         Out);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_out", 32'(Out), 32'(e.out));
                chk("sb_sel", 32'(MuxSelect), 32'(e.sel));
            end
        end
    end

    initial begin
        logic [7:0] pat;
        int c1;
        int c2;
        Resetn = 1'b0;
        Enable = 1'b1;
        Req    = 8'hFF;
        MuxIn  = 8'h00;
        step();
        step();
        chk("rst_grant", 32'(Grant), 0);
        chk("rst_sel", 32'(MuxSelect), 0);
        chk("rst_out", 32'(Out), 0);
        chk("rst_valid", 32'(Valid), 0);
        chk("rst_tmo", 32'(Timeout), 0);

        Resetn = 1'b1;
        Req    = 8'h01;
        MuxIn  = 8'h01;
        run_grant(0, 1'b1);

        Req    = 8'h00;
        Resetn = 1'b0;
        step();
        chk("rst2_grant", 32'(Grant), 0);
        chk("rst2_valid", 32'(Valid), 0);

        Resetn = 1'b1;
        Req    = 8'hFF;
        pat    = 8'hA5;
        MuxIn  = pat;
        c1 = cyc;
        for (int i = 0; i < 8; i++) run_grant(i, pat[i]);
        c2 = cyc;
        run_grant(0, pat[0]);
        chk("rr_period", 32'(c2 - c1), 40);

        Req = 8'h40;
        run_grant(6, pat[6]);
        Req = 8'h41;
        run_grant(0, pat[0]);
        run_grant(6, pat[6]);
        Req = 8'h80;
        run_grant(7, pat[7]);
        run_grant(7, pat[7]);

        Req   = 8'h08;
        MuxIn = 8'h08;
        push_exp(3, 1'b1, 1);
        step();
        chk("early_grant", 32'(Grant), 32'(8'h08));
        chk("early_sel", 32'(MuxSelect), 3);
        step();
        chk("early_grant2", 32'(Grant), 32'(8'h08));
        Req = 8'h00;
        step();
        chk("early_rel", 32'(Grant), 0);
        chk("early_tmo", 32'(Timeout), 0);
        chk("early_valid", 32'(Valid), 0);

        Req   = 8'hFF;
        MuxIn = 8'h10;
        push_exp(4, 1'b1, 1);
        step();
        chk("en_grant", 32'(Grant), 32'(8'h10));
        step();
        chk("en_grant2", 32'(Grant), 32'(8'h10));
        Enable = 1'b0;
        step();
        chk("en_rel", 32'(Grant), 0);
        chk("en_valid", 32'(Valid), 0);
        chk("en_tmo", 32'(Timeout), 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("en_idle_grant", 32'(Grant), 0);
            chk("en_idle_valid", 32'(Valid), 0);
        end

        Enable = 1'b1;
        Req    = 8'h20;
        MuxIn  = 8'h20;
        push_exp(5, 1'b1, 1);
        step();
        chk("mid_grant", 32'(Grant), 32'(8'h20));
        step();
        chk("mid_sel", 32'(MuxSelect), 5);
        Resetn = 1'b0;
        step();
        chk("mid_rst_grant", 32'(Grant), 0);
        chk("mid_rst_sel", 32'(MuxSelect), 0);
        chk("mid_rst_out", 32'(Out), 0);
        chk("mid_rst_valid", 32'(Valid), 0);
        chk("mid_rst_tmo", 32'(Timeout), 0);

        Resetn = 1'b1;
        Req    = 8'hFF;
        MuxIn  = 8'h01;
        run_grant(0, 1'b1);
        Req = 8'h00;
        repeat (3) step();
        chk("sb_drained", 32'(sbq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
